// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: packs core retirement/memory activity into trace records in a FWFT FIFO, with in-band overflow markers
module riscv_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int LOST_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [31:0]              reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [31:0]              wr_data,
    input  logic [31:0]              rd_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [81:0]              trace_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [31:0]              lost_total
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, LOST} state_t;

    state_t             r_state;
    logic [81:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [LOST_W-1:0]  r_lost_cnt;
    logic [31:0]        r_lost_total;

    logic               w_reg;
    logic               w_event;
    logic               w_pop;
    logic               w_can_push;
    logic               w_push;
    logic               w_drop;
    logic [LOST_W-1:0]  w_lost_next;
    logic [81:0]        w_record;
    logic [81:0]        w_marker;

    assign w_reg       = reg_write_sig & (reg_num != 5'd0);
    assign w_event     = trace_en & (w_reg | wr | rd);
    assign w_record    = {1'b0, w_reg, wr, rd,
                          w_reg ? reg_num : 5'd0,
                          w_reg ? reg_data : 32'd0,
                          (wr | rd) ? addr : 9'd0,
                          wr ? wr_data : (rd ? rd_data : 32'd0)};
    assign w_lost_next = &r_lost_cnt ? r_lost_cnt : r_lost_cnt + LOST_W'(w_event);
    assign w_marker    = {1'b1, 49'd0, 32'(w_lost_next)};
    assign w_pop       = trace_valid & trace_ready;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign w_can_push  = (r_count < (AW+1)'(DEPTH)) | w_pop;
    assign w_push      = w_can_push & ((r_state == RUN) ? w_event : 1'b1);
    assign w_drop      = w_event & ((r_state == LOST) | ~w_can_push);

    assign trace_valid = (r_count != '0);
    assign trace_data  = trace_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count  = r_count;
    assign lost_total  = r_lost_total;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= (r_state == RUN) ? w_record : w_marker;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_lost_cnt   <= '0;
            r_lost_total <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (r_state == RUN && w_event && !w_can_push) begin
                r_state    <= LOST;
                r_lost_cnt <= LOST_W'(1);
            end else if (r_state == LOST) begin
                r_lost_cnt <= w_can_push ? '0 : w_lost_next;
                if (w_can_push) r_state <= RUN;
            end
            if (w_drop && !(&r_lost_total)) r_lost_total <= r_lost_total + 32'd1;
        end
    end
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: randomized scoreboard bench against a queue-based reference model
module tb_riscv_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b1;
    logic        reg_write_sig = 1'b0;
    logic [4:0]  reg_num = '0;
    logic [31:0] reg_data = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [81:0] trace_data;
    logic [4:0]  fifo_count;
    logic [31:0] lost_total;

    riscv_trace_buffer #(.DEPTH(DEPTH), .LOST_W(16)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .fifo_count(fifo_count), .lost_total(lost_total)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [81:0] exp_q[$];
    int          m_count = 0;
    bit          m_lost = 0;
    int          m_drops = 0;
    int unsigned m_total = 0;
    bit          m_reg, m_ev, m_pop, m_room, m_push;
    int          m_d;

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: a queue of expected records plus a drop tally
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_count = 0;
            m_lost = 0;
            m_drops = 0;
            m_total = 0;
        end else begin
            m_reg  = reg_write_sig && reg_num != 5'd0;
            m_ev   = trace_en && (m_reg || wr || rd);
            m_pop  = m_count > 0 && trace_ready;
            m_room = m_count < DEPTH || m_pop;
            m_push = 0;
            if (!m_lost) begin
                if (m_ev && m_room) begin
                    exp_q.push_back({1'b0, m_reg, wr, rd,
                                     m_reg ? reg_num : 5'd0,
                                     m_reg ? reg_data : 32'd0,
                                     (wr || rd) ? addr : 9'd0,
                                     wr ? wr_data : (rd ? rd_data : 32'd0)});
                    m_push = 1;
                end else if (m_ev) begin
                    m_lost = 1;
                    m_drops = 1;
                    m_total++;
                end
            end else begin
                if (m_ev) m_total++;
                m_d = m_drops + int'(m_ev);
                if (m_d > 65535) m_d = 65535;
                if (m_room) begin
                    exp_q.push_back({1'b1, 49'd0, 32'(m_d)});
                    m_push = 1;
                    m_lost = 0;
                    m_drops = 0;
                end else m_drops = m_d;
            end
            m_count = m_count + int'(m_push) - int'(m_pop);
        end
    end

    logic [81:0] prev_data = '0;
    bit          prev_stall = 0;

    always @(negedge clk) begin
        chk("valid", 82'(trace_valid), 82'(m_count != 0));
        chk("count", 82'(fifo_count), 82'(m_count));
        chk("lost_total", 82'(lost_total), 82'(m_total));
        if (prev_stall && trace_valid) chk("stable", trace_data, prev_data);
        if (trace_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL record: got %h expected none", trace_data);
            end else chk("record", trace_data, exp_q.pop_front());
        end
        prev_stall = trace_valid && !trace_ready;
        prev_data = trace_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write_sig = 0;
        wr = 0;
        rd = 0;
    endtask

    task automatic rand_ev();
        reg_write_sig = 1'($urandom_range(0, 1));
        reg_num = 5'($urandom);
        reg_data = $urandom;
        wr = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        addr = 9'($urandom);
        wr_data = $urandom;
        rd_data = $urandom;
        if (!wr && !rd && (!reg_write_sig || reg_num == 5'd0)) wr = 1;
    endtask

    task automatic drain();
        idle();
        trace_ready = 1;
        for (int i = 0; i < 100 && (trace_valid || m_count != 0); i++) step();
        chk("drained", 82'(trace_valid), 82'(0));
    endtask

    int unsigned saved;
    int          issued;

    initial begin
        repeat (3) step();
        chk("reset_valid", 82'(trace_valid), 82'(0));
        chk("reset_data", trace_data, 82'(0));
        reset = 0;
        step();

        trace_ready = 0;
        reg_write_sig = 1; reg_num = 5; reg_data = 32'hDEADBEEF;
        step();
        idle();
        chk("single_flags", 82'(trace_data[80:78]), 82'(3'b100));
        chk("single_num", 82'(trace_data[77:73]), 82'(5));
        chk("single_data", 82'(trace_data[72:41]), 82'(32'hDEADBEEF));
        chk("single_count", 82'(fifo_count), 82'(1));
        drain();

        reg_write_sig = 1; reg_num = 0; reg_data = 32'h55;
        step();
        idle();
        chk("x0_filtered", 82'(trace_valid), 82'(0));
        wr = 1; rd = 1; addr = 9'h1A5; wr_data = 32'h11; rd_data = 32'h22;
        trace_ready = 0;
        step();
        idle();
        chk("comb_flags", 82'(trace_data[80:78]), 82'(3'b011));
        chk("comb_addr", 82'(trace_data[40:32]), 82'(9'h1A5));
        chk("comb_mem", 82'(trace_data[31:0]), 82'(32'h11));
        drain();

        trace_ready = 0;
        for (int i = 0; i < 20; i++) begin rand_ev(); step(); end
        chk("ovf_lost_total", 82'(lost_total), 82'(4));
        chk("ovf_count", 82'(fifo_count), 82'(16));
        trace_ready = 1;
        for (int i = 0; i < 30; i++) begin rand_ev(); step(); end
        drain();

        trace_ready = 0;
        for (int i = 0; i < 16; i++) begin rand_ev(); step(); end
        saved = lost_total;
        trace_ready = 1;
        rand_ev();
        step();
        idle();
        chk("fullpop_count", 82'(fifo_count), 82'(16));
        chk("fullpop_nolost", 82'(lost_total), 82'(saved));
        drain();

        issued = 0;
        for (int c = 0; c < 2000 && issued < 100; c++) begin
            trace_ready = 1'($urandom_range(0, 1));
            if (m_count < 4) begin rand_ev(); issued++; end else idle();
            step();
        end
        chk("bp_issued", 82'(issued), 82'(100));
        chk("bp_nolost", 82'(lost_total), 82'(saved));
        drain();

        trace_ready = 0;
        for (int i = 0; i < 19; i++) begin rand_ev(); step(); end
        idle();
        reset = 1;
        #1;
        chk("rst_valid", 82'(trace_valid), 82'(0));
        chk("rst_count", 82'(fifo_count), 82'(0));
        chk("rst_lost", 82'(lost_total), 82'(0));
        step();
        reset = 0;
        step();
        reg_write_sig = 1; reg_num = 7; reg_data = 32'h12345678;
        step();
        idle();
        chk("post_rst_head", 82'(trace_data[81:78]), 82'(4'b0100));
        drain();
        chk("queue_empty", 82'(exp_q.size()), 82'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
